// File: rtl/grf_bypass.sv
// grf_bypass: 32 x 32-bit general register file with same-cycle write bypass.
//
// Ports:
//   clk      rising-edge clock for all register state
//   reset    asynchronous active-high reset; clears every register at once
//   WE       writeback write enable
//   A1, A2   combinational read addresses (rs / rt)
//   A3       writeback address (0 = discard)
//   WD       writeback data
//   WPC      PC of the writing-back instruction, used only by the trace
//   RD1, RD2 read data; return WD when the port address matches a live write
//
// Parameter:
//   TRACE_EN 1 prints one trace line per enabled write edge in simulation.
module grf_bypass #(
  parameter int TRACE_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [4:0]  A3,
  input  logic [31:0] WD,
  input  logic [31:0] WPC,
  output logic [31:0] RD1,
  output logic [31:0] RD2
);

  logic [31:0][31:0] regs_q, regs_d;
  logic              wr_en;

  // A write to $0 is architecturally discarded, so it neither updates state
  // nor qualifies for the bypass. An unknown WE resolves to "no write" in the
  // if-statements below, keeping X/Z off the stored state.
  assign wr_en = WE && (A3 != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[A3] = WD;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  // Reads are combinational; the bypass hands the consumer the value that
  // the current edge is about to commit. Reset forces both ports to zero.
  always_comb begin
    RD1 = '0;
    if (!reset && (A1 != 5'd0)) begin
      if (wr_en && (A1 == A3)) RD1 = WD;
      else                     RD1 = regs_q[A1];
    end
  end

  always_comb begin
    RD2 = '0;
    if (!reset && (A2 != 5'd0)) begin
      if (wr_en && (A2 == A3)) RD2 = WD;
      else                     RD2 = regs_q[A2];
    end
  end

`ifndef SYNTHESIS
  // Writeback trace; also reports $0 writes even though they are dropped.
  always @(posedge clk) begin
    if ((TRACE_EN != 0) && (reset === 1'b0) && (WE === 1'b1))
      $display("@%h: $%2d <= %h", WPC, A3, WD);
  end
`endif

endmodule

// File: doc/grf_bypass.md
GRF_BYPASS -- requirements
Module: grf_bypass

Interface
REQ-001 Parameter TRACE_EN, default 1, enables the simulation write-trace message (1 = on, 0 = silent).
REQ-002 clk  input  1  rising-edge clock for all register state.
REQ-003 reset  input  1  asynchronous, active-high; clears the register array.
REQ-004 WE  input  1  write enable for the writeback port.
REQ-005 A1  input  5  read address, port 1 (rs).
REQ-006 A2  input  5  read address, port 2 (rt).
REQ-007 A3  input  5  write address; driven by the write-address select stage (rd / rt / 31).
REQ-008 WD  input  32  write data; driven by the writeback-data select stage (ALU result / DM read data / PC+4).
REQ-009 WPC  input  32  PC of the instruction currently writing back; used only for the trace.
REQ-010 RD1  output  32  read data, port 1.
REQ-011 RD2  output  32  read data, port 2.

Function
REQ-012 The block SHALL hold 32 general registers of 32 bits, indexed 0-31.
REQ-013 Register 0 SHALL always read as 32'h00000000; writes to address 0 SHALL NOT change any stored state.
REQ-014 Write: on a rising clk edge with reset=0, WE=1 and A3!=0, reg[A3] SHALL take WD, visible from the next cycle.
REQ-015 With WE=0, no register SHALL change on a clock edge, regardless of A3 or WD.
REQ-016 Reads SHALL be combinational, with zero cycle latency from A1/A2 to RD1/RD2.
REQ-017 Internal bypass: while WE=1, A3!=0 and A1==A3, RD1 SHALL equal WD in the same cycle; otherwise RD1 SHALL equal reg[A1].
REQ-018 The same bypass rule SHALL apply independently to RD2 with A2.
REQ-019 A1==A2==A3 with WE=1 and A3!=0 SHALL forward WD on both ports at once.
REQ-020 A1==0 or A2==0 SHALL return 0 even when WE=1 and A3==0 with nonzero WD; the bypass is disqualified for address 0.
REQ-021 Trace, simulation only: when TRACE_EN=1, each rising clk edge with reset=0 and WE=1 SHALL print one line "@<WPC 8 hex>: $<A3 2-digit decimal> <= <WD 8 hex>".
REQ-022 The trace SHALL also print for A3==0, where the write is architecturally discarded.
REQ-023 No trace line SHALL be printed while reset=1 or while WE=0.
REQ-024 X or Z on A3, WD or WE while WE is not 1 SHALL NOT corrupt any register.

Reset
REQ-025 Asserting reset SHALL clear all 32 registers to 0 immediately, without waiting for clk.
REQ-026 While reset=1, RD1 and RD2 SHALL be 0 for any address, with the bypass suppressed.
REQ-027 A write coinciding with a clock edge during reset SHALL be discarded and not traced.
REQ-028 After reset deasserts, the first rising edge SHALL be a normal write edge.
REQ-029 Reset asserted between two writes SHALL wipe the earlier write; a subsequent read of that register SHALL return 0.

Verification
REQ-030 Reset pulse, then read all 32 addresses -> RD1=RD2=0 for every address.
REQ-031 WE=1, A3=8, WD=32'h12345678, WPC=32'h00003000, one edge; then A1=8 -> RD1=32'h12345678; trace "@00003000: $ 8 <= 12345678".
REQ-032 WE=1, A3=5, WD=32'hDEADBEEF, A1=5, A2=5 before the edge -> RD1=RD2=32'hDEADBEEF in the same cycle; after the edge with WE=0 -> still 32'hDEADBEEF.
REQ-033 WE=1, A3=0, WD=32'hFFFFFFFF, A1=0 -> RD1=0 before and after the edge; trace line printed with $ 0.
REQ-034 Write 32'hA5A5A5A5 to register 31, assert reset mid-cycle with no clk edge -> RD1 (A1=31) drops to 0 immediately.
REQ-035 WE=0, A3=3, WD=32'h1 across 4 edges -> register 3 stays 0; no trace output.
